// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding and
// the default bus-stall timeout.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with locked cycles on one slave bus.
// Optional stall timeout with bus error: define WB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant, slave bus quiet, arbitrating on cyc
// GNT0  | master 0 owns the slave bus while m0_cyc_i stays high
// GNT1  | master 1 owns the slave bus while m1_cyc_i stays high
// ERR   | owner timed out; bus quiet until the owner drops cyc
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack_i
);

  arb_state_e state_q;
  logic       last_q;
  logic       own_q;
  logic       own_cyc;
  logic       own_stb;

  assign own_cyc = own_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own_q ? m1_stb_i : m0_stb_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
  logic       timeout_hit;

  // Hit on the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = ((state_q == GNT0) || (state_q == GNT1)) && own_cyc &&
                       own_stb && !s_ack_i && (cnt_q == CntLast);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef WB_ARB_TIMEOUT_EN
          cnt_q <= '0;
`endif
          // On a tie, last_q names the master that must yield.
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= GNT0;
            own_q   <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q <= GNT1;
            own_q   <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            last_q  <= own_q;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q <= ERR;
            cnt_q   <= '0;
          end else if (s_ack_i) begin
            cnt_q <= '0;
          end else if (own_stb) begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        ERR: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            last_q  <= own_q;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state_q)
      GNT0: begin
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_sel_o   = m0_sel_i;
        m0_ack_o  = s_ack_i;
        m0_data_o = s_data_i;
      end
      GNT1: begin
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_sel_o   = m1_sel_i;
        m1_ack_o  = s_ack_i;
        m1_data_o = s_data_i;
      end
      default: ;
    endcase
`ifdef WB_ARB_TIMEOUT_EN
    if (timeout_hit) begin
      m0_err_o = !own_q;
      m1_err_o = own_q;
    end
`endif
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: per-cycle vector table plus hand-written
// lock, timeout and round-robin sequences.
module tb_wb_arbiter2;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam logic [AW-1:0] A0   = 30'h4000000;
  localparam logic [AW-1:0] A1   = 30'h1234567;
  localparam logic [DW-1:0] D0   = 32'hCAFE0000;
  localparam logic [DW-1:0] D1   = 32'h0000BEEF;
  localparam logic [SW-1:0] SEL0 = 4'hF;
  localparam logic [SW-1:0] SEL1 = 4'h3;
  localparam logic [DW-1:0] SDAT = 32'h5A5A1234;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_data_i;
  logic [SW-1:0] m0_sel_i;
  logic [DW-1:0] m0_data_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_data_i;
  logic [SW-1:0] m1_sel_i;
  logic [DW-1:0] m1_data_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_data_i;
  logic          s_ack_i;

  wb_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic       c0, s0, w0;
    logic       c1, s1, w1;
    logic       ack;
    logic [1:0] gnt;   // 0 none, 1 master 0, 2 master 1
  } vec_t;

  vec_t          tbl[$];
  vec_t          exp_q[$];
  logic [DW-1:0] beat_q[$];
  int            checks = 0;
  int            failures = 0;

  function automatic vec_t mk(logic r, logic c0, logic s0, logic w0, logic c1,
                              logic s1, logic w1, logic ack, logic [1:0] gnt);
    vec_t v;
    v.rst = r; v.c0 = c0; v.s0 = s0; v.w0 = w0;
    v.c1 = c1; v.s1 = s1; v.w1 = w1; v.ack = ack; v.gnt = gnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_i = v.rst;
    m0_cyc_i = v.c0; m0_stb_i = v.s0; m0_we_i = v.w0;
    m1_cyc_i = v.c1; m1_stb_i = v.s1; m1_we_i = v.w1;
    s_ack_i = v.ack;
    s_data_i = SDAT;
  endtask

  task automatic check_vec(input vec_t e, input int idx);
    logic ecyc, estb, ewe, ea0, ea1;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edat, ed0, ed1;
    logic [SW-1:0] esel;
    ecyc = 0; estb = 0; ewe = 0; ea0 = 0; ea1 = 0;
    eaddr = '0; edat = '0; ed0 = '0; ed1 = '0; esel = '0;
    if (e.gnt == 2'd1) begin
      ecyc = e.c0; estb = e.s0; ewe = e.w0; eaddr = A0; edat = D0; esel = SEL0;
      ea0 = e.ack; ed0 = SDAT;
    end else if (e.gnt == 2'd2) begin
      ecyc = e.c1; estb = e.s1; ewe = e.w1; eaddr = A1; edat = D1; esel = SEL1;
      ea1 = e.ack; ed1 = SDAT;
    end
    chk($sformatf("v%0d s_cyc", idx), 64'(s_cyc_o), 64'(ecyc));
    chk($sformatf("v%0d s_stb", idx), 64'(s_stb_o), 64'(estb));
    chk($sformatf("v%0d s_we", idx), 64'(s_we_o), 64'(ewe));
    chk($sformatf("v%0d s_addr", idx), 64'(s_addr_o), 64'(eaddr));
    chk($sformatf("v%0d s_data", idx), 64'(s_data_o), 64'(edat));
    chk($sformatf("v%0d s_sel", idx), 64'(s_sel_o), 64'(esel));
    chk($sformatf("v%0d m0_ack", idx), 64'(m0_ack_o), 64'(ea0));
    chk($sformatf("v%0d m1_ack", idx), 64'(m1_ack_o), 64'(ea1));
    chk($sformatf("v%0d m0_data", idx), 64'(m0_data_o), 64'(ed0));
    chk($sformatf("v%0d m1_data", idx), 64'(m1_data_o), 64'(ed1));
    chk($sformatf("v%0d errs", idx), 64'({m0_err_o, m1_err_o}), 64'(0));
  endtask

  initial begin
    vec_t e;
    int   waited;
    int   errs;
    logic exp_err, exp_cyc;

    rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    m0_addr_i = A0; m0_data_i = D0; m0_sel_i = SEL0;
    m1_addr_i = A1; m1_data_i = D1; m1_sel_i = SEL1;
    s_ack_i = 0; s_data_i = '0;
    repeat (2) @(posedge clk_i);

    //                rst c0 s0 w0 c1 s1 w1 ack gnt
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));  // reset state
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));  // m0 request, not yet granted
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 1));  // ack on 2nd granted cycle
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));  // reset restores last=1
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0));  // tie
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));  // m0 drops and re-raises
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1, 2));  // waiting m1 wins
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0));  // m1 write
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 2));  // reset mid-grant
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 1));  // m0 wins after reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk_i); #1;
      apply(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk_i);
      e = exp_q.pop_front();
      check_vec(e, i);
    end

    // m1 locks four beats while m0 also requests (last=0, so m1 wins the tie)
    @(posedge clk_i); #1;
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
    s_ack_i = 0;
    waited = 0;
    @(negedge clk_i);
    while (!(s_cyc_o && s_addr_o == A1) && waited < 4) begin
      @(negedge clk_i);
      waited++;
    end
    chk("lock m1 grant", 64'(s_cyc_o && s_addr_o == A1), 64'(1));
    for (int b = 0; b < 4; b++) begin
      @(posedge clk_i); #1;
      s_ack_i = 1;
      s_data_i = 32'hB0000000 + 32'(b);
      beat_q.push_back(s_data_i);
      @(negedge clk_i);
      chk($sformatf("lock b%0d m0_ack", b), 64'(m0_ack_o), 64'(0));
      chk($sformatf("lock b%0d m1_ack", b), 64'(m1_ack_o), 64'(1));
      if (m1_ack_o && beat_q.size() > 0)
        chk($sformatf("lock b%0d m1_data", b), 64'(m1_data_o), 64'(beat_q.pop_front()));
    end
    chk("lock beats left", 64'(beat_q.size()), 64'(0));
    @(posedge clk_i); #1;
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    waited = 0;
    @(negedge clk_i);
    while (!(s_cyc_o && s_addr_o == A0) && waited < 4) begin
      @(negedge clk_i);
      waited++;
    end
    chk("lock m0 grant after", 64'(s_cyc_o && s_addr_o == A0), 64'(1));
    chk("lock m0 grant wait", 64'(waited), 64'(2));
    @(posedge clk_i); #1;
    m0_cyc_i = 0; m0_stb_i = 0;
    repeat (2) @(posedge clk_i);

    // stall sequence: m0 strobes, slave never acks
    #1;
    m0_cyc_i = 1; m0_stb_i = 1;
    @(negedge clk_i);
    chk("to request cycle s_cyc", 64'(s_cyc_o), 64'(0));
    errs = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = (n == 8);
      exp_cyc = (n <= 8);
`else
      exp_err = 1'b0;
      exp_cyc = 1'b1;
`endif
      if (m0_err_o) errs++;
      chk($sformatf("to n%0d m0_err", n), 64'(m0_err_o), 64'(exp_err));
      chk($sformatf("to n%0d s_cyc", n), 64'(s_cyc_o), 64'(exp_cyc));
      chk($sformatf("to n%0d m1_err", n), 64'(m1_err_o), 64'(0));
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("to err pulses", 64'(errs), 64'(1));
`else
    chk("to err pulses", 64'(errs), 64'(0));
`endif
    @(posedge clk_i); #1;
    m0_cyc_i = 0; m0_stb_i = 0;
    @(posedge clk_i); #1;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    @(negedge clk_i);
    chk("to idle s_cyc", 64'(s_cyc_o), 64'(0));
    @(negedge clk_i);
    chk("to m1 wins after release", 64'(s_cyc_o && s_addr_o == A1), 64'(1));
    @(posedge clk_i); #1;
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    repeat (2) @(posedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
